key_debounce: RTL

//  Debounces and edge-detects the board push-buttons (50 MHz clk, active-low raw keys).

---
 rtl/key_debounce.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/key_debounce.sv
// Per-key 2-FF synchronizer, debounce FSM and press/release pulse generator (active-low keys).
// Optional long-press detection is enabled by defining KEY_LONG_PRESS_EN.
module key_debounce #(
    parameter int KEY_W     = 4,
    parameter int DEB_TIME  = 1_000_000,
    parameter int LONG_TIME = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key,
    output logic [KEY_W-1:0] key_out,
    output logic [KEY_W-1:0] key_press,
    output logic [KEY_W-1:0] key_release
`ifdef KEY_LONG_PRESS_EN
    ,
    output logic [KEY_W-1:0] key_long
`endif
);

    localparam int              CNT_W   = $clog2(DEB_TIME);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_TIME - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PRESS_F = 2'd1;
    localparam logic [1:0] DOWN    = 2'd2;
    localparam logic [1:0] REL_F   = 2'd3;

`ifdef KEY_LONG_PRESS_EN
    localparam int               HOLD_W   = $clog2(LONG_TIME);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_TIME - 1);
`endif

    if (DEB_TIME < 2 || LONG_TIME < 2) begin : g_param_check
        $error("key_debounce: DEB_TIME and LONG_TIME must be >= 2");
    end

    logic [KEY_W-1:0] sync_1;
    logic [KEY_W-1:0] ks;

    // Idle level is 1 (released), so the synchronizer comes out of reset as "not pressed".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= '1;
            ks     <= '1;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks, so each flop samples pre-edge values.
            sync_1 <= key;
            ks     <= sync_1;
        end
    end

    for (genvar i = 0; i < KEY_W; i++) begin : g_key
        logic [1:0]       state;
        logic [CNT_W-1:0] cnt;
        logic             out_q;
        logic             press_q;
        logic             rel_q;
        logic             filter_done;

        assign filter_done = (cnt == CNT_MAX);

        always_ff @(posedge clk or negedge rst_n) begin
            // NOTE: all per-key state (FSM, counter, outputs) is async-reset; nothing relies on power-up values.
            if (!rst_n) begin
                state   <= IDLE;
                cnt     <= '0;
                out_q   <= 1'b1;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                case (state)
                    IDLE: begin
                        if (!ks[i]) begin
                            state <= PRESS_F;
                            cnt   <= '0;
                        end
                    end
                    PRESS_F: begin
                        if (ks[i]) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (filter_done) begin
                            state   <= DOWN;
                            out_q   <= 1'b0;
                            press_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DOWN: begin
                        if (ks[i]) begin
                            state <= REL_F;
                            cnt   <= '0;
                        end
                    end
                    default: begin
                        if (!ks[i]) begin
                            state <= DOWN;
                            cnt   <= '0;
                        end else if (filter_done) begin
                            state <= IDLE;
                            out_q <= 1'b1;
                            rel_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                endcase
            end
        end

        assign key_out[i]     = out_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = rel_q;

`ifdef KEY_LONG_PRESS_EN
        logic [HOLD_W-1:0] hold;
        logic              long_fired;
        logic              long_q;
        logic              hold_clear;

        // Hold time restarts on each accepted press and whenever the key is back in IDLE.
        assign hold_clear = (state == IDLE)
                          || (state == PRESS_F && !ks[i] && filter_done)
                          || (state == REL_F && ks[i] && filter_done);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold       <= '0;
                long_fired <= 1'b0;
                long_q     <= 1'b0;
            end else begin
                long_q <= 1'b0;
                if (hold_clear) begin
                    hold       <= '0;
                    long_fired <= 1'b0;
                end else if (state == DOWN || state == REL_F) begin
                    if (hold != HOLD_MAX) begin
                        hold <= hold + 1'b1;
                    end else if (!long_fired) begin
                        long_q     <= 1'b1;
                        long_fired <= 1'b1;
                    end
                end
            end
        end

        assign key_long[i] = long_q;
`endif
    end

endmodule
